// File: rtl/octet_pkg.sv
// Shared encodings for the octet math datapath: FSM states and op codes.
package octet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add8_seq_if.sv
// Request/result handshake bundle between execute, the sequencer and writeback.
interface add8_seq_if #(
    parameter int BYTES = 4
);
    localparam int W = 8 * BYTES;

    logic         start_valid;
    logic         start_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    // Requester/consumer side
    modport master (
        output start_valid, op_sub, a, b, abort, res_ready,
        input  start_ready, res_valid, result, carry_out, overflow, zero
    );

    // Sequencer side
    modport slave (
        input  start_valid, op_sub, a, b, abort, res_ready,
        output start_ready, res_valid, result, carry_out, overflow, zero
    );

endinterface

// File: rtl/add8.sv
// Existing 8-bit ripple byte adder with carry in/out.
module add8 (
    input  logic [7:0] i_in1,
    input  logic [7:0] i_in2,
    input  logic       i_carry_in,
    output logic [7:0] o_sum,
    output logic       o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_in1} + {1'b0, i_in2} + {8'd0, i_carry_in};

endmodule

// File: rtl/add8_seq.sv
// Multi-precision add/subtract: one byte per cycle through a single add8,
// LSB first, with the carry chained through a register.
module add8_seq
    import octet_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    add8_seq_if.slave  bus
);

    localparam int W  = 8 * BYTES;
    localparam int CW = $clog2(BYTES + 1);

    state_t          r_state;
    state_t          w_next;

    logic [W-1:0]    r_a_sh;
    logic [W-1:0]    r_b_sh;
    logic [W-1:0]    r_res_sh;
    logic [W-1:0]    r_result;
    logic            r_carry;
    logic            r_zacc;
    logic            r_carry_out;
    logic            r_ovf;
    logic            r_zero;
    logic [CW-1:0]   r_cnt;

    logic [7:0]      w_sum;
    logic            w_carry;
    logic            w_last;
    logic [W+7:0]    w_res_cat;

    // Signed overflow: like-signed operands producing a differently-signed sum
    function automatic logic f_ovf(input logic a7, input logic b7, input logic s7);
        return (a7 == b7) && (s7 != a7);
    endfunction

    add8 u_add8 (
        .i_in1      (r_a_sh[7:0]),
        .i_in2      (r_b_sh[7:0]),
        .i_carry_in (r_carry),
        .o_sum      (w_sum),
        .o_carry    (w_carry)
    );

    assign w_last    = (r_cnt == CW'(BYTES - 1));
    // New byte enters from the top so the LSB ends up at bit 0 after BYTES shifts
    assign w_res_cat = {w_sum, r_res_sh};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; abort wins over the result handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start_valid) w_next = ST_RUN;
            ST_RUN: begin
                if (bus.abort)   w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.abort)          w_next = ST_IDLE;
                else if (bus.res_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand shifters, carry chain, counter and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zacc      <= 1'b0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        r_a_sh  <= bus.a;
                        // Subtract as a + ~b + 1: the +1 rides in on the initial carry
                        r_b_sh  <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
                        r_carry <= bus.op_sub;
                        r_cnt   <= '0;
                        r_zacc  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_zero      <= 1'b0;
                    end else begin
                        r_a_sh   <= r_a_sh >> 8;
                        r_b_sh   <= r_b_sh >> 8;
                        r_res_sh <= w_res_cat[W+7:8];
                        r_carry  <= w_carry;
                        r_zacc   <= r_zacc & (w_sum == 8'd0);
                        r_cnt    <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_result    <= w_res_cat[W+7:8];
                            r_carry_out <= w_carry;
                            r_ovf       <= f_ovf(r_a_sh[7], r_b_sh[7], w_sum[7]);
                            r_zero      <= r_zacc & (w_sum == 8'd0);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.abort) begin
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_zero      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = (r_state == ST_IDLE);
    assign bus.res_valid   = (r_state == ST_DONE);
    assign bus.result      = r_result;
    assign bus.carry_out   = r_carry_out;
    assign bus.overflow    = r_ovf;
    assign bus.zero        = r_zero;

endmodule

// File: tb/tb_add8_seq.sv
// Scoreboard bench for add8_seq: a 4-byte and a 1-byte instance.
module tb_add8_seq;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
        int          acc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    logic pv4 = 1'b0;
    logic pv1 = 1'b0;

    add8_seq_if #(.BYTES(4)) b4 ();
    add8_seq_if #(.BYTES(1)) b1 ();

    add8_seq #(.BYTES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    add8_seq #(.BYTES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word two's complement add/sub on nb bytes
    function automatic exp_t model(input logic sub, input logic [31:0] a, input logic [31:0] b, input int nb);
        exp_t        e;
        int          n;
        logic [63:0] m, aa, bx, full, r;
        n    = 8 * nb;
        m    = (64'd1 << n) - 64'd1;
        aa   = {32'd0, a} & m;
        bx   = {32'd0, (sub ? ~b : b)} & m;
        full = aa + bx + {63'd0, sub};
        r    = full & m;
        e.res = r[31:0];
        e.co  = full[n];
        e.ov  = (aa[n-1] == bx[n-1]) && (r[n-1] != aa[n-1]);
        e.z   = (r == 64'd0);
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input int sel, input logic sub, input logic [31:0] a, input logic [31:0] b, input bit push);
        int   n;
        exp_t e;
        n = 0;
        if (sel == 4) begin
            b4.op_sub = sub; b4.a = a; b4.b = b; b4.start_valid = 1'b1;
        end else begin
            b1.op_sub = sub; b1.a = a[7:0]; b1.b = b[7:0]; b1.start_valid = 1'b1;
        end
        while (((sel == 4) ? !b4.start_ready : !b1.start_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("accept_timeout", (sel == 4) ? b4.start_ready : b1.start_ready, 1);
        @(posedge clk); #1;
        // Scramble operands after accept; they must not affect the result
        if (sel == 4) begin
            b4.start_valid = 1'b0; b4.a = ~a; b4.b = ~b; b4.op_sub = ~sub;
        end else begin
            b1.start_valid = 1'b0; b1.a = ~a[7:0]; b1.b = ~b[7:0]; b1.op_sub = ~sub;
        end
        if (push) begin
            e = model(sub, a, b, (sel == 4) ? 4 : 1);
            e.acc = cyc;
            if (sel == 4) q4.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", q4.size() + q1.size(), 0);
    endtask

    // Result monitor, 4-byte instance
    always @(negedge clk) begin
        exp_t e;
        if (b4.res_valid && !pv4) begin
            if (q4.size() == 0) check("spurious4", b4.res_valid, 0);
            else                check("lat4", cyc - q4[0].acc, 4);
        end
        if (b4.res_valid && b4.res_ready && q4.size() != 0) begin
            e = q4.pop_front();
            check("res4", b4.result, e.res);
            check("co4", b4.carry_out, e.co);
            check("ov4", b4.overflow, e.ov);
            check("z4", b4.zero, e.z);
        end
        pv4 <= b4.res_valid;
    end

    // Result monitor, 1-byte instance
    always @(negedge clk) begin
        exp_t e;
        if (b1.res_valid && !pv1) begin
            if (q1.size() == 0) check("spurious1", b1.res_valid, 0);
            else                check("lat1", cyc - q1[0].acc, 1);
        end
        if (b1.res_valid && b1.res_ready && q1.size() != 0) begin
            e = q1.pop_front();
            check("res1", b1.result, e.res[7:0]);
            check("co1", b1.carry_out, e.co);
            check("ov1", b1.overflow, e.ov);
            check("z1", b1.zero, e.z);
        end
        pv1 <= b1.res_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        rst_n = 1'b0;
        b4.start_valid = 0; b4.op_sub = 0; b4.a = 0; b4.b = 0; b4.abort = 0; b4.res_ready = 1;
        b1.start_valid = 0; b1.op_sub = 0; b1.a = 0; b1.b = 0; b1.abort = 0; b1.res_ready = 1;
        #12;
        check("rst_ready4", b4.start_ready, 1);
        check("rst_valid4", b4.res_valid, 0);
        check("rst_res4", b4.result, 0);
        check("rst_flags4", {b4.carry_out, b4.overflow, b4.zero}, 0);
        check("rst_ready1", b1.start_ready, 1);
        check("rst_valid1", b1.res_valid, 0);
        check("rst_res1", b1.result, 0);
        check("rst_flags1", {b1.carry_out, b1.overflow, b1.zero}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed add/sub cases
        issue(4, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1);
        drain();
        issue(4, 1'b1, 32'h0000_0000, 32'h0000_0001, 1);
        issue(4, 1'b1, 32'h0000_0005, 32'h0000_0005, 1);
        issue(4, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1);
        issue(4, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        issue(4, 1'b1, 32'h8000_0000, 32'h0000_0001, 1);
        drain();

        // Random back-to-back traffic
        for (int i = 0; i < 8; i++)
            issue(4, 1'($urandom_range(0, 1)), $urandom, $urandom, 1);
        drain();

        // Backpressure: hold result 5 cycles while a second request waits
        b4.res_ready = 1'b0;
        issue(4, 1'b0, 32'h1234_5678, 32'h1111_1111, 1);
        e = model(1'b0, 32'h1234_5678, 32'h1111_1111, 4);
        n = 0;
        while (!b4.res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_rise", b4.res_valid, 1);
        b4.op_sub = 1'b1; b4.a = 32'h10; b4.b = 32'h20; b4.start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", b4.res_valid, 1);
            check("bp_ready", b4.start_ready, 0);
            check("bp_res", b4.result, e.res);
            check("bp_flags", {b4.carry_out, b4.overflow, b4.zero}, {e.co, e.ov, e.z});
        end
        b4.res_ready = 1'b1;
        issue(4, 1'b1, 32'h0000_0010, 32'h0000_0020, 1);
        drain();

        // Abort on the second RUN cycle
        issue(4, 1'b0, 32'h0000_0003, 32'h0000_0004, 0);
        @(posedge clk); #1;
        b4.abort = 1'b1;
        @(posedge clk); #1;
        b4.abort = 1'b0;
        check("abort_ready", b4.start_ready, 1);
        check("abort_valid", b4.res_valid, 0);
        check("abort_res", b4.result, 0);
        check("abort_flags", {b4.carry_out, b4.overflow, b4.zero}, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (b4.res_valid) n++;
        end
        check("abort_no_valid", n, 0);

        // Asynchronous reset mid-RUN
        issue(4, 1'b0, 32'h0000_0011, 32'h0000_0022, 1);
        drain();
        issue(4, 1'b0, 32'h0000_0005, 32'h0000_0006, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_ready", b4.start_ready, 1);
        check("arst_valid", b4.res_valid, 0);
        check("arst_res", b4.result, 0);
        check("arst_flags", {b4.carry_out, b4.overflow, b4.zero}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-byte instance
        issue(1, 1'b1, 32'h80, 32'h01, 1);
        issue(1, 1'b0, 32'hFF, 32'h01, 1);
        issue(1, 1'b0, 32'h40, 32'h40, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add8_seq.md
# add8_seq

Multi-precision add/subtract sequencer for the octet math datapath. It owns one `add8` instance and runs it once per byte, least-significant byte first, chaining the carry through a register. This lets a BYTES-wide add or subtract complete in BYTES cycles on the existing 8-bit adder. It sits between the instruction-execute logic (which issues requests) and the result writeback (which consumes results), with valid/ready handshakes on both sides.

## Interface

- BYTES, 4: operand width in bytes; legal range 1..16; operand width W = 8*BYTES.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  request present.
- start_ready  output  1  block can accept a request (high only in IDLE).
- op_sub  input  1  0 = a+b, 1 = a-b; sampled at accept.
- a  input  W  first operand; sampled at accept.
- b  input  W  second operand; sampled at accept.
- abort  input  1  synchronous cancel of the current operation.
- res_valid  output  1  result present.
- res_ready  input  1  consumer takes result.
- result  output  W  sum or difference, modulo 2^W.
- carry_out  output  1  final carry; for subtract, 1 = no borrow.
- overflow  output  1  signed (two's complement) overflow.
- zero  output  1  result == 0.

## Operation

- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - start_ready = 1.
  - On start_valid && start_ready: latch a into a_sh and b' = (op_sub ? ~b : b) into b_sh.
  - Set carry register = op_sub, byte counter = 0, zero-accumulator = 1.
  - Go to RUN.
- **RUN, each cycle:**
  - add8 inputs: in1 = a_sh[7:0], in2 = b_sh[7:0], carry_in = carry register.
  - Shift a_sh and b_sh right by 8.
  - Shift the add8 sum into result_sh from the top.
  - Carry register <= add8 carry.
  - zero-accumulator &= (sum == 0).
  - Counter +1.
- **RUN, on the cycle with counter == BYTES-1:**
  - overflow <= (a_msb == b'_msb) && (sum[7] != a_msb), where the msb values are bit 7 of the bytes fed to add8 in that cycle.
  - carry_out <= add8 carry.
  - Go to DONE.
- **DONE:**
  - res_valid = 1.
  - result, carry_out, overflow and zero are held stable until res_valid && res_ready.
  - Then go to IDLE.
- **abort:**
  - In RUN or DONE, go to IDLE on the next edge.
  - No res_valid is produced and output registers are cleared to 0.
  - abort in IDLE is ignored.
  - abort has priority over a res_ready handshake in the same cycle.
- **Counter:** $clog2(BYTES+1) bits. When BYTES=1, RUN lasts exactly one cycle.
- start_valid while not in IDLE is ignored; the requester must hold it.
- Operands changing after accept have no effect.

## Timing

- **Reset (rst_n low, asynchronous):**
  - State = IDLE, so start_ready = 1.
  - res_valid = 0; result, carry_out, overflow and zero = 0.
  - All shift registers and the counter are cleared.
  - Reset mid-RUN or mid-DONE discards the operation.
- **Latency:** the accept edge is T0. res_valid rises after edge T_BYTES, i.e. BYTES cycles after accept.
- **Throughput:** one operation per BYTES+2 cycles at best:
  - accept (IDLE) → BYTES RUN cycles → one DONE cycle with res_ready high → back to IDLE.
- There is no accept in the same cycle as a DONE handshake; start_ready stays 0 until IDLE.
- start_ready is a decode of registered state. Outputs are registered; there are no combinational input-to-output paths.
- The critical path is one add8 ripple plus the carry-register setup.

## Structure

- **Shared package `octet_pkg`:**
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - the op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1.
- **Sub-module:** exactly one `add8` instance (existing byte adder) used as the per-byte datapath.
- No other sub-modules; the FSM, shift registers, counter and flag logic are local.

## Test plan

- BYTES=4, add 0x000000FF + 0x00000001 → result 0x00000100, carry_out 0, overflow 0, zero 0; res_valid asserted exactly 4 cycles after the accept edge.
- BYTES=4, sub 0x00000000 - 0x00000001 → 0xFFFFFFFF, carry_out 0 (borrow), overflow 0. Then sub 0x00000005 - 0x00000005 → 0, carry_out 1, zero 1.
- BYTES=4, add 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow 1. Then add 0xFFFFFFFF + 0x00000001 → 0x00000000, carry_out 1, zero 1, overflow 0.
- Backpressure: res_ready held low 5 cycles in DONE → result and flags stable, start_ready 0, a second start_valid not accepted. When res_ready rises, the handshake completes, then IDLE and the second request is accepted.
- abort on the 2nd RUN cycle → IDLE next edge, res_valid never rises, outputs 0. rst_n pulsed low mid-RUN → all outputs at reset values immediately, without a clock edge.
- BYTES=1 instance, sub 0x80 - 0x01 → 0x7F, overflow 1, carry_out 1; res_valid 1 cycle after accept.
